// File: rtl/drm_ctrl_pkg.sv
// Shared definitions for the DRM metering arbiter.
//   - default parameter values for the arbiter and its round-robin selector
//   - FSM state encoding and the fixed back-off length after an ack timeout
//   - id_width(): CU index width, never narrower than one bit so that a
//     single-CU build still has a real (constant zero) id port
package drm_ctrl_pkg;

   localparam int DEF_NUM_CU      = 4;
   localparam int DEF_CNT_W       = 8;
   localparam int DEF_ACK_TIMEOUT = 1024;
   localparam int DEF_ACT_W       = 128;
   localparam int BACKOFF_CYCLES  = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_BACKOFF = 2'd2
   } drm_state_e;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/drm_rr_arbiter.sv
// Combinational round-robin selector.
// The search starts at last_grant+1 (mod NUM_CU) and returns the first
// requesting index found.
//   req         : one request bit per CU (CU has pending events)
//   last_grant  : index granted most recently
//   grant_valid : at least one request is present
//   grant_id    : chosen CU index (0 when grant_valid is low)
module drm_rr_arbiter
   import drm_ctrl_pkg::*;
#(
   parameter int NUM_CU = DEF_NUM_CU,
   parameter int ID_W   = id_width(NUM_CU)
) (
   input  logic [NUM_CU-1:0] req,
   input  logic [ID_W-1:0]   last_grant,
   output logic              grant_valid,
   output logic [ID_W-1:0]   grant_id
);

   always_comb begin
      int               idx;
      logic [NUM_CU-1:0] shifted;
      grant_valid = 1'b0;
      grant_id    = '0;
      idx         = 0;
      shifted     = '0;
      for (int k = 0; k < NUM_CU; k++) begin
         idx     = (int'(last_grant) + 1 + k) % NUM_CU;
         shifted = req >> idx;
         if (!grant_valid && shifted[0]) begin
            grant_valid = 1'b1;
            grant_id    = idx[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/drm_metering_arbiter.sv
// Shares one DRM activator metering port between NUM_CU compute units.
// Each CU's usage pulses are counted in a saturating pending counter; a
// round-robin FSM drains the counters one event at a time over a
// valid/ack handshake, abandoning a grant after ACK_TIMEOUT cycles.
//
// Ports
//   ap_clk, ap_rst_n   : clock, synchronous active-low reset
//   cu_event           : per-CU one-cycle usage pulses
//   activation_code    : activator code, bit 0 = IP activated
//   metering_event     : event valid toward the activator
//   metering_cu_id     : CU index of the presented event
//   event_accepted     : activator ack; transfer = valid & ack
//   cu_enable          : registered run permission per CU
//   cu_pending_full    : CU counter at its maximum
//   overflow_sticky    : an event was dropped on a saturated counter
//   timeout_sticky     : a grant was abandoned on timeout
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for activation and a non-zero pending counter
// ISSUE   | metering_event held for one CU until ack or timeout
// BACKOFF | fixed pause after a timeout before the next grant
module drm_metering_arbiter
   import drm_ctrl_pkg::*;
#(
   parameter int NUM_CU      = DEF_NUM_CU,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
   parameter int ACT_W       = DEF_ACT_W,
   parameter int ID_W        = id_width(NUM_CU)
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic [NUM_CU-1:0] cu_event,
   input  logic [ACT_W-1:0]  activation_code,
   output logic              metering_event,
   output logic [ID_W-1:0]   metering_cu_id,
   input  logic              event_accepted,
   output logic [NUM_CU-1:0] cu_enable,
   output logic [NUM_CU-1:0] cu_pending_full,
   output logic [NUM_CU-1:0] overflow_sticky,
   output logic              timeout_sticky
);

   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
   localparam int BO_W = $clog2(BACKOFF_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   drm_state_e        state;
   logic [CNT_W-1:0]  cnt [NUM_CU];
   logic [ID_W-1:0]   last_grant;
   logic [TO_W-1:0]   timeout_cnt;
   logic [BO_W-1:0]   backoff_cnt;
   logic [NUM_CU-1:0] req;
   logic [NUM_CU-1:0] dec_vec;
   logic              grant_valid;
   logic [ID_W-1:0]   grant_id;
   logic              act;
   logic              xfer;

   assign act  = activation_code[0];
   assign xfer = (state == ST_ISSUE) && metering_event && event_accepted;

   // Only bit 0 of the activation code carries meaning here.
   generate
      if (ACT_W > 1) begin : g_act_unused
         logic unused_act_bits;
         assign unused_act_bits = ^activation_code[ACT_W-1:1];
      end
   endgenerate

   always_comb begin
      req             = '0;
      dec_vec         = '0;
      cu_pending_full = '0;
      for (int i = 0; i < NUM_CU; i++) begin
         req[i]             = (cnt[i] != '0);
         cu_pending_full[i] = (cnt[i] == CNT_MAX);
         dec_vec[i]         = xfer && (int'(metering_cu_id) == i);
      end
   end

   drm_rr_arbiter #(
      .NUM_CU (NUM_CU),
      .ID_W   (ID_W)
   ) u_rr (
      .req         (req),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   // Simultaneous increment and decrement cancel, so a saturated counter
   // that is also being drained does not flag an overflow.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < NUM_CU; i++) begin
            cnt[i] <= '0;
         end
         overflow_sticky <= '0;
      end else begin
         for (int i = 0; i < NUM_CU; i++) begin
            if (cu_event[i] && !dec_vec[i]) begin
               if (cnt[i] == CNT_MAX) begin
                  overflow_sticky[i] <= 1'b1;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end else if (!cu_event[i] && dec_vec[i]) begin
               cnt[i] <= cnt[i] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state          <= ST_IDLE;
         metering_event <= 1'b0;
         metering_cu_id <= '0;
         last_grant     <= ID_W'(NUM_CU - 1);
         timeout_cnt    <= '0;
         backoff_cnt    <= '0;
         timeout_sticky <= 1'b0;
         cu_enable      <= '0;
      end else begin
         cu_enable <= {NUM_CU{act}};
         case (state)
            ST_IDLE: begin
               if (act && grant_valid) begin
                  metering_event <= 1'b1;
                  metering_cu_id <= grant_id;
                  timeout_cnt    <= '0;
                  state          <= ST_ISSUE;
               end
            end
            // Deactivation is deliberately ignored here: an open handshake
            // always completes or times out.
            ST_ISSUE: begin
               if (xfer) begin
                  metering_event <= 1'b0;
                  last_grant     <= metering_cu_id;
                  state          <= ST_IDLE;
               end else begin
                  timeout_cnt <= timeout_cnt + 1'b1;
                  if (timeout_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                     metering_event <= 1'b0;
                     timeout_sticky <= 1'b1;
                     // Treat the abandoned CU as last served so the
                     // others get the next grants.
                     last_grant     <= metering_cu_id;
                     backoff_cnt    <= BO_W'(BACKOFF_CYCLES - 1);
                     state          <= ST_BACKOFF;
                  end
               end
            end
            ST_BACKOFF: begin
               if (backoff_cnt == '0) begin
                  state <= ST_IDLE;
               end else begin
                  backoff_cnt <= backoff_cnt - 1'b1;
               end
            end
            default: begin
               metering_event <= 1'b0;
               state          <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_drm_metering_arbiter.sv
// Directed bench for drm_metering_arbiter: a 4-CU instance (CNT_W=2,
// ACK_TIMEOUT=8) and a single-CU instance sharing clock, reset and
// activation. Inputs change and outputs are sampled on the falling edge.
module tb_drm_metering_arbiter;

   logic         ap_clk = 1'b0;
   logic         ap_rst_n;
   logic [3:0]   cu_event;
   logic [127:0] activation_code;
   logic         event_accepted;
   logic         metering_event;
   logic [1:0]   metering_cu_id;
   logic [3:0]   cu_enable;
   logic [3:0]   cu_pending_full;
   logic [3:0]   overflow_sticky;
   logic         timeout_sticky;

   logic [0:0]   cu_event_one;
   logic         ack_one;
   logic         metering_event_one;
   logic [0:0]   metering_cu_id_one;
   logic [0:0]   cu_enable_one;
   logic [0:0]   full_one;
   logic [0:0]   ovf_one;
   logic         timeout_one;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int xfer_ids[$];
   int xfer_cyc[$];

   always #5 ap_clk = ~ap_clk;

   drm_metering_arbiter #(
      .NUM_CU(4), .CNT_W(2), .ACK_TIMEOUT(8), .ACT_W(128)
   ) dut (
      .ap_clk          (ap_clk),
      .ap_rst_n        (ap_rst_n),
      .cu_event        (cu_event),
      .activation_code (activation_code),
      .metering_event  (metering_event),
      .metering_cu_id  (metering_cu_id),
      .event_accepted  (event_accepted),
      .cu_enable       (cu_enable),
      .cu_pending_full (cu_pending_full),
      .overflow_sticky (overflow_sticky),
      .timeout_sticky  (timeout_sticky)
   );

   drm_metering_arbiter #(
      .NUM_CU(1), .CNT_W(2), .ACK_TIMEOUT(8), .ACT_W(128)
   ) dut_one (
      .ap_clk          (ap_clk),
      .ap_rst_n        (ap_rst_n),
      .cu_event        (cu_event_one),
      .activation_code (activation_code),
      .metering_event  (metering_event_one),
      .metering_cu_id  (metering_cu_id_one),
      .event_accepted  (ack_one),
      .cu_enable       (cu_enable_one),
      .cu_pending_full (full_one),
      .overflow_sticky (ovf_one),
      .timeout_sticky  (timeout_one)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs n cycles, pulsing ev on iterations first..last, and logs every
   // transfer seen on the 4-CU port.
   task automatic run(input int n, input logic [3:0] ev, input int first, input int last);
      for (int k = 0; k < n; k++) begin
         cu_event = (k >= first && k <= last) ? ev : 4'h0;
         @(negedge ap_clk);
         cyc++;
         if (metering_event && event_accepted) begin
            xfer_ids.push_back(int'(metering_cu_id));
            xfer_cyc.push_back(cyc);
         end
      end
      cu_event = 4'h0;
   endtask

   task automatic clear_log();
      xfer_ids.delete();
      xfer_cyc.delete();
   endtask

   task automatic do_reset();
      ap_rst_n = 1'b0;
      cu_event = 4'h0;
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      clear_log();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      ap_rst_n        = 1'b0;
      cu_event        = 4'h0;
      activation_code = '0;
      event_accepted  = 1'b0;
      cu_event_one    = 1'b0;
      ack_one         = 1'b1;
      repeat (3) @(negedge ap_clk);

      // reset state
      check("rst_event",   32'(metering_event), 32'd0);
      check("rst_id",      32'(metering_cu_id), 32'd0);
      check("rst_enable",  32'(cu_enable), 32'h0);
      check("rst_full",    32'(cu_pending_full), 32'h0);
      check("rst_ovf",     32'(overflow_sticky), 32'h0);
      check("rst_timeout", 32'(timeout_sticky), 32'd0);
      check("rst_cnt2",    32'(dut.cnt[2]), 32'd0);
      check("rst_one_evt", 32'(metering_event_one), 32'd0);

      ap_rst_n        = 1'b1;
      activation_code = 128'h1;
      event_accepted  = 1'b1;
      @(negedge ap_clk);
      check("enable_on",     32'(cu_enable), 32'hF);
      check("one_enable_on", 32'(cu_enable_one), 32'h1);

      // three events on CU2, ack tied high
      clear_log();
      run(10, 4'b0100, 0, 2);
      check("t1_count", 32'(xfer_ids.size()), 32'd3);
      if (xfer_ids.size() == 3) begin
         for (int i = 0; i < 3; i++) check("t1_id", 32'(xfer_ids[i]), 32'd2);
         check("t1_gap_a", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd2);
         check("t1_gap_b", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd2);
      end
      check("t1_cnt2", 32'(dut.cnt[2]), 32'd0);

      // single-CU build: id fixed at 0
      cu_event_one = 1'b1;
      @(negedge ap_clk);
      cu_event_one = 1'b0;
      check("one_idle", 32'(metering_event_one), 32'd0);
      @(negedge ap_clk);
      check("one_evt", 32'(metering_event_one), 32'd1);
      check("one_id",  32'(metering_cu_id_one), 32'd0);
      @(negedge ap_clk);
      check("one_done", 32'(metering_event_one), 32'd0);
      check("one_cnt",  32'(dut_one.cnt[0]), 32'd0);

      // round-robin order from reset
      do_reset();
      run(12, 4'hF, 0, 0);
      check("t2_count", 32'(xfer_ids.size()), 32'd4);
      if (xfer_ids.size() == 4)
         for (int i = 0; i < 4; i++) check("t2_order", 32'(xfer_ids[i]), 32'(i));
      clear_log();
      run(8, 4'b1010, 0, 0);
      check("t2b_count", 32'(xfer_ids.size()), 32'd2);
      if (xfer_ids.size() == 2) begin
         check("t2b_first",  32'(xfer_ids[0]), 32'd1);
         check("t2b_second", 32'(xfer_ids[1]), 32'd3);
      end

      // saturation while deactivated (CNT_W=2 -> max 3)
      activation_code = '0;
      do_reset();
      for (int p = 1; p <= 5; p++) begin
         cu_event = 4'b0001;
         @(negedge ap_clk);
         check("t3_full", 32'(cu_pending_full[0]), 32'(p >= 3));
         check("t3_ovf",  32'(overflow_sticky[0]), 32'(p >= 4));
      end
      cu_event = 4'h0;
      @(negedge ap_clk);
      check("t3_no_issue", 32'(metering_event), 32'd0);
      check("t3_enable",   32'(cu_enable), 32'h0);
      activation_code = 128'h1;
      clear_log();
      run(12, 4'h0, 1, 0);
      check("t3_count", 32'(xfer_ids.size()), 32'd3);
      if (xfer_ids.size() == 3)
         for (int i = 0; i < 3; i++) check("t3_id", 32'(xfer_ids[i]), 32'd0);
      check("t3_full_after", 32'(cu_pending_full[0]), 32'd0);
      check("t3_ovf_kept",   32'(overflow_sticky[0]), 32'd1);

      // increment coincident with transfer on CU1
      do_reset();
      run(2, 4'b0010, 0, 0);
      check("t4_first", 32'(xfer_ids.size()), 32'd1);
      run(1, 4'b0010, 0, 0);
      check("t4_cnt_kept", 32'(dut.cnt[1]), 32'd1);
      run(6, 4'h0, 1, 0);
      check("t4_count", 32'(xfer_ids.size()), 32'd2);
      if (xfer_ids.size() == 2) check("t4_id2", 32'(xfer_ids[1]), 32'd1);
      check("t4_cnt_end", 32'(dut.cnt[1]), 32'd0);

      // ack timeout, back-off and re-issue
      do_reset();
      event_accepted = 1'b0;
      cu_event = 4'b0010;
      @(negedge ap_clk);
      cu_event = 4'h0;
      @(negedge ap_clk);
      check("t5_id", 32'(metering_cu_id), 32'd1);
      for (int i = 0; i < 8; i++) begin
         check("t5_held", 32'(metering_event), 32'd1);
         @(negedge ap_clk);
      end
      check("t5_drop",    32'(metering_event), 32'd0);
      check("t5_sticky",  32'(timeout_sticky), 32'd1);
      check("t5_cnt",     32'(dut.cnt[1]), 32'd1);
      for (int i = 0; i < 15; i++) begin
         @(negedge ap_clk);
         check("t5_backoff", 32'(metering_event), 32'd0);
      end
      w = 0;
      do begin
         @(negedge ap_clk);
         w++;
      end while (!metering_event && w < 4);
      check("t5_reissue_wait", 32'(w), 32'd2);
      check("t5_reissue_id",   32'(metering_cu_id), 32'd1);
      check("t5_reissue_cnt",  32'(dut.cnt[1]), 32'd1);
      event_accepted = 1'b1;
      @(negedge ap_clk);
      check("t5_accepted", 32'(metering_event), 32'd0);
      check("t5_cnt_end",  32'(dut.cnt[1]), 32'd0);

      // reset during an accepted handshake
      do_reset();
      event_accepted = 1'b0;
      cu_event = 4'b1000;
      @(negedge ap_clk);
      cu_event = 4'h0;
      @(negedge ap_clk);
      check("t6_pre_evt", 32'(metering_event), 32'd1);
      check("t6_pre_id",  32'(metering_cu_id), 32'd3);
      event_accepted = 1'b1;
      ap_rst_n       = 1'b0;
      @(negedge ap_clk);
      check("t6_evt",    32'(metering_event), 32'd0);
      check("t6_id",     32'(metering_cu_id), 32'd0);
      check("t6_enable", 32'(cu_enable), 32'h0);
      check("t6_full",   32'(cu_pending_full), 32'h0);
      check("t6_ovf",    32'(overflow_sticky), 32'h0);
      check("t6_to",     32'(timeout_sticky), 32'd0);
      check("t6_cnt3",   32'(dut.cnt[3]), 32'd0);
      ap_rst_n = 1'b1;
      clear_log();
      run(8, 4'h0, 1, 0);
      check("t6_no_xfer", 32'(xfer_ids.size()), 32'd0);

      // deactivation mid-handshake keeps the grant, then blocks new ones
      event_accepted = 1'b0;
      cu_event = 4'b0001;
      @(negedge ap_clk);
      cu_event = 4'h0;
      @(negedge ap_clk);
      activation_code = '0;
      repeat (3) @(negedge ap_clk);
      check("t7_held", 32'(metering_event), 32'd1);
      event_accepted = 1'b1;
      @(negedge ap_clk);
      check("t7_done", 32'(metering_event), 32'd0);
      check("t7_cnt",  32'(dut.cnt[0]), 32'd0);
      clear_log();
      run(6, 4'b0001, 0, 0);
      check("t7_blocked", 32'(xfer_ids.size()), 32'd0);
      check("t7_pending", 32'(dut.cnt[0]), 32'd1);
      activation_code = 128'h1;
      run(6, 4'h0, 1, 0);
      check("t7_resume", 32'(xfer_ids.size()), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/drm_metering_arbiter.md
DRM_METERING_ARBITER -- requirements
Module: drm_metering_arbiter

Interface
REQ-001 SHALL have parameter NUM_CU, default 4, number of compute units sharing one DRM activator metering port.
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-CU pending-event counter.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 1024, cycles to wait for event_accepted before abandoning a grant.
REQ-004 SHALL have parameter ACT_W, default 128, activation code width.
REQ-005 SHALL have a single clock and a reset that is synchronous and active-low; all ports below are in that clock domain.
REQ-006 ap_clk  input  1  clock; all logic on its rising edge.
REQ-007 ap_rst_n  input  1  synchronous active-low reset.
REQ-008 cu_event  input  NUM_CU  per-CU one-cycle usage pulse; each high cycle counts as one event.
REQ-009 activation_code  input  ACT_W  code from the DRM activator; bit 0 high means the IP is activated.
REQ-010 metering_event  output  1  valid toward the activator, held until accepted or timed out.
REQ-011 metering_cu_id  output  clog2(NUM_CU)  CU index of the current event, stable while metering_event is high.
REQ-012 event_accepted  input  1  ready/ack from the activator; a transfer occurs when metering_event and event_accepted are both high.
REQ-013 cu_enable  output  NUM_CU  registered run permission per CU.
REQ-014 cu_pending_full  output  NUM_CU  counter of CU i is at its maximum, 2^CNT_W-1.
REQ-015 overflow_sticky  output  NUM_CU  an event was dropped because the counter was saturated.
REQ-016 timeout_sticky  output  1  at least one grant hit ACK_TIMEOUT.

Function
REQ-017 Each CU SHALL have a pending counter: +1 on cu_event[i], -1 on a transfer with metering_cu_id==i.
REQ-018 If increment and decrement hit the same counter in one cycle, it SHALL be left unchanged.
REQ-019 A saturated counter SHALL ignore increments and set overflow_sticky[i]; the sticky flag is cleared only by reset.
REQ-020 cu_pending_full[i] SHALL equal (count_i == 2^CNT_W-1) combinationally from the counter register.
REQ-021 cu_enable[i] SHALL be activation_code[0] registered one cycle, for all i.
REQ-022 FSM states SHALL be IDLE, ISSUE and BACKOFF.
REQ-023 IDLE -> ISSUE SHALL occur when activation_code[0]=1 and any count>0.
  - The grant is chosen round-robin, starting the search at last_grant+1 modulo NUM_CU.
  - metering_event rises the next cycle with metering_cu_id registered.
REQ-024 In ISSUE, a transfer SHALL decrement the count, set last_grant to the granted id, drop metering_event and return to IDLE.
  - Maximum throughput is therefore one event every 2 cycles.
REQ-025 In ISSUE, the timeout counter SHALL increment each cycle without a transfer.
  - On reaching ACK_TIMEOUT: drop metering_event, set timeout_sticky, leave the count unchanged, go to BACKOFF.
REQ-026 BACKOFF SHALL last exactly 16 cycles, then go to IDLE, with last_grant advanced so that other CUs are served first.
REQ-027 Deactivation (activation_code[0] falling) during ISSUE SHALL NOT abort the handshake; no new grant SHALL start while deactivated.
REQ-028 The timeout counter SHALL clear on every entry to ISSUE.
REQ-029 NUM_CU=1 SHALL be supported, with metering_cu_id fixed at 0.

Reset
REQ-030 While ap_rst_n=0, at a clock edge all of the following SHALL clear:
  - metering_event=0, metering_cu_id=0, cu_enable=0
  - all counters=0, both sticky outputs=0
  - last_grant=NUM_CU-1, state=IDLE, timeout and backoff counters=0
REQ-031 Reset asserted mid-handshake SHALL drop metering_event at the next edge; a coincident event_accepted SHALL be ignored.

Structure
REQ-032 The FSM state enum, BACKOFF_CYCLES=16 and the default parameter values SHALL live in package drm_ctrl_pkg.
REQ-033 Round-robin selection SHALL be a combinational sub-module drm_rr_arbiter.
  - Inputs: request vector and last_grant.
  - Outputs: grant_valid and grant_id.
REQ-034 Counters and FSM SHALL stay in drm_metering_arbiter.

Verification
REQ-035 Reset, activate, pulse cu_event[2] three times, event_accepted tied high:
  - Expect three transfers with id=2, each 2 cycles apart.
  - Expect count_2 back at 0.
REQ-036 One event on each CU 0-3 in the same cycle:
  - Expect grant order 0,1,2,3.
  - Then one more event on CU1 and CU3: expect order 1,3.
REQ-037 With CNT_W=2, pulse cu_event[0] five times while deactivated:
  - Expect cu_pending_full[0]=1 after the 3rd pulse.
  - Expect overflow_sticky[0]=1 after the 4th.
  - After activation, expect exactly 3 transfers.
REQ-038 ACK_TIMEOUT=8, event_accepted tied low, one event on CU1:
  - Expect metering_event high for 8 cycles, then timeout_sticky=1 and 16 idle cycles.
  - Expect a re-issue of id=1 with count_1 still 1.
REQ-039 cu_event[1] pulsed in the same cycle as the CU1 transfer:
  - Expect count_1 unchanged.
  - Expect a second event for id=1 after returning to IDLE.
REQ-040 Assert ap_rst_n=0 while metering_event=1 and event_accepted=1:
  - Expect all outputs 0 the next cycle.
  - Expect no further transfer after reset releases.
